alu_arbiter: RTL and testbench

Shares the single combinational `alu` instance between two requesters: port 0 (main pipeline execute stage) and port 1 (auxiliary unit, e.g. address/compare helper). Accepts one operation at a time via valid/ready handshake, drives registered operands into the ALU, captures `ALUOut`/`Branch_Enable` one cycle later and returns them to the granted requester via a valid/ready response channel. Sits between the requesters and the ALU; the ALU itself is unchanged.

---
 rtl/alu_arbiter_if.sv | 36 +++
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters and alu_arbiter.
// The master side belongs to the requesters and the slave side to the arbiter.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [6:0]  req0_ctl;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [6:0]  req1_ctl;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_branch;

    modport master (
        output req0_valid, req0_ctl, req0_a, req0_b,
        output req1_valid, req1_ctl, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_branch
    );

    modport slave (
        input  req0_valid, req0_ctl, req0_a, req0_b,
        input  req1_valid, req1_ctl, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_branch
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters; response valid two edges after accept.
// A held response blocks new accepts; the next request is taken in the cycle the response handshakes.
module alu_arbiter #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus,
    output logic [6:0]   alu_ctl,
    output logic [31:0]  alu_a,
    output logic [31:0]  alu_b,
    input  logic [31:0]  alu_out,
    input  logic         alu_branch
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [6:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    state_t      state;
    state_t      state_nxt;
    logic        grant;
    logic        last_grant;
    op_t         op_q;
    op_t         op_in;
    logic [31:0] result_q;
    logic        branch_q;

    logic        rsp_hs;
    logic        can_accept;
    logic        prefer1;
    logic        win0;
    logic        win1;
    logic        accept;

    // Port 1 takes a tie only in round-robin mode and only when port 0 was served last.
    always_comb begin
        rsp_hs     = (state == RESP) && (grant ? bus.rsp1_ready : bus.rsp0_ready);
        can_accept = !reset && ((state == IDLE) || rsp_hs);
        prefer1    = (FIXED_PRIORITY == 0) && !last_grant;
        win1       = bus.req1_valid && (!bus.req0_valid || prefer1);
        win0       = bus.req0_valid && !win1;
        accept     = can_accept && (win0 || win1);
        op_in      = win1 ? op_t'{bus.req1_ctl, bus.req1_a, bus.req1_b}
                          : op_t'{bus.req0_ctl, bus.req0_a, bus.req0_b};
    end

    assign bus.req0_ready = can_accept && win0;
    assign bus.req1_ready = can_accept && win1;
    assign bus.rsp0_valid = !reset && (state == RESP) && !grant;
    assign bus.rsp1_valid = !reset && (state == RESP) && grant;
    assign bus.rsp_result = result_q;
    assign bus.rsp_branch = branch_q;

    assign alu_ctl = op_q.ctl;
    assign alu_a   = op_q.a;
    assign alu_b   = op_q.b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (rsp_hs) begin
                    state_nxt = accept ? EXEC : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // last_grant resets to 1 so that the first tie after reset goes to port 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            op_q       <= '0;
            result_q   <= '0;
            branch_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q       <= op_in;
                grant      <= win1;
                last_grant <= win1;
            end
            if (state == EXEC) begin
                result_q <= alu_out;
                branch_q <= alu_branch;
            end
        end
    end

    a_one_ready: assert property (@(posedge clk) !(bus.req0_ready && bus.req1_ready));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one round-robin and one fixed-priority instance, each with a behavioural ALU.
module tb_alu_arbiter;
    localparam logic [6:0] C_ADD  = 7'd0;
    localparam logic [6:0] C_SUB  = 7'd1;
    localparam logic [6:0] C_OR   = 7'd2;
    localparam logic [6:0] C_XOR  = 7'd3;
    localparam logic [6:0] C_BEQ  = 7'd5;
    localparam logic [6:0] C_BLT  = 7'd6;
    localparam logic [6:0] C_BLTU = 7'd7;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [32:0] alu_model(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        r = '0;
        case (c)
            C_ADD:   r[31:0] = a + b;
            C_SUB:   r[31:0] = a - b;
            C_OR:    r[31:0] = a | b;
            C_XOR:   r[31:0] = a ^ b;
            C_BEQ:   r[32]   = (a == b);
            C_BLT:   r[32]   = ($signed(a) < $signed(b));
            C_BLTU:  r[32]   = (a < b);
            default: r       = '0;
        endcase
        return r;
    endfunction

    alu_arbiter_if bus_rr();
    alu_arbiter_if bus_fp();
    logic [6:0]  rr_ctl, fp_ctl;
    logic [31:0] rr_a, rr_b, rr_out, fp_a, fp_b, fp_out;
    logic        rr_br, fp_br;

    assign {rr_br, rr_out} = alu_model(rr_ctl, rr_a, rr_b);
    assign {fp_br, fp_out} = alu_model(fp_ctl, fp_a, fp_b);

    alu_arbiter #(.FIXED_PRIORITY(0)) dut_rr (
        .clk(clk), .reset(reset), .bus(bus_rr),
        .alu_ctl(rr_ctl), .alu_a(rr_a), .alu_b(rr_b), .alu_out(rr_out), .alu_branch(rr_br)
    );

    alu_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .reset(reset), .bus(bus_fp),
        .alu_ctl(fp_ctl), .alu_a(fp_a), .alu_b(fp_b), .alu_out(fp_out), .alu_branch(fp_br)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_rr.req0_valid = 1'b1;
        tick();
        tick();
        #1;
        total++; if (bus_rr.req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", bus_rr.req0_ready); end
        total++; if ({bus_rr.rsp1_valid, bus_rr.rsp0_valid} !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b want=00", {bus_rr.rsp1_valid, bus_rr.rsp0_valid}); end
        total++; if ({rr_ctl, rr_a, rr_b} !== 71'd0) begin bad++; $display("FAIL reset_operands got=%h want=0", {rr_ctl, rr_a, rr_b}); end
        total++; if ({bus_rr.rsp_branch, bus_rr.rsp_result} !== 33'd0) begin bad++; $display("FAIL reset_result got=%h want=0", {bus_rr.rsp_branch, bus_rr.rsp_result}); end
        bus_rr.req0_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single();
        tick();
        bus_rr.req0_valid = 1'b1; bus_rr.req0_ctl = C_ADD; bus_rr.req0_a = 32'd5; bus_rr.req0_b = 32'd3;
        bus_rr.rsp0_ready = 1'b1;
        #1;
        total++; if (bus_rr.req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%0b want=1", bus_rr.req0_ready); end
        tick();
        bus_rr.req0_valid = 1'b0;
        #1;
        total++; if ({bus_rr.rsp1_valid, bus_rr.rsp0_valid} !== 2'b00) begin bad++; $display("FAIL single_exec_valid got=%b want=00", {bus_rr.rsp1_valid, bus_rr.rsp0_valid}); end
        total++; if ({rr_ctl, rr_a, rr_b} !== {C_ADD, 32'd5, 32'd3}) begin bad++; $display("FAIL single_operands got=%h want=%h", {rr_ctl, rr_a, rr_b}, {C_ADD, 32'd5, 32'd3}); end
        tick();
        #1;
        total++; if ({bus_rr.rsp1_valid, bus_rr.rsp0_valid} !== 2'b01) begin bad++; $display("FAIL single_rsp_valid got=%b want=01", {bus_rr.rsp1_valid, bus_rr.rsp0_valid}); end
        total++; if (bus_rr.rsp_result !== 32'd8) begin bad++; $display("FAIL single_result got=%0d want=8", bus_rr.rsp_result); end
        tick();
        #1;
        total++; if ({bus_rr.rsp1_valid, bus_rr.rsp0_valid} !== 2'b00) begin bad++; $display("FAIL single_done got=%b want=00", {bus_rr.rsp1_valid, bus_rr.rsp0_valid}); end
        bus_rr.rsp0_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_res [2];
        exp_res[0] = 32'd6;
        exp_res[1] = 32'hFF;
        do_reset();
        bus_rr.req0_valid = 1'b1; bus_rr.req0_ctl = C_SUB; bus_rr.req0_a = 32'd10;   bus_rr.req0_b = 32'd4;
        bus_rr.req1_valid = 1'b1; bus_rr.req1_ctl = C_OR;  bus_rr.req1_a = 32'hF0;   bus_rr.req1_b = 32'h0F;
        bus_rr.rsp0_ready = 1'b1; bus_rr.rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            int p;
            p = i % 2;
            total++; if ({bus_rr.req1_ready, bus_rr.req0_ready} !== (p == 1 ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_grant op=%0d got=%b want_port=%0d", i, {bus_rr.req1_ready, bus_rr.req0_ready}, p); end
            tick(); #1;
            total++; if ({bus_rr.rsp1_valid, bus_rr.rsp0_valid} !== 2'b00) begin bad++; $display("FAIL rr_exec op=%0d got=%b want=00", i, {bus_rr.rsp1_valid, bus_rr.rsp0_valid}); end
            tick(); #1;
            total++; if ({bus_rr.rsp1_valid, bus_rr.rsp0_valid} !== (p == 1 ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_rsp_valid op=%0d got=%b want_port=%0d", i, {bus_rr.rsp1_valid, bus_rr.rsp0_valid}, p); end
            total++; if (bus_rr.rsp_result !== exp_res[p]) begin bad++; $display("FAIL rr_result op=%0d got=%h want=%h", i, bus_rr.rsp_result, exp_res[p]); end
        end
        bus_rr.req0_valid = 1'b0; bus_rr.req1_valid = 1'b0;
        tick(); #1;
        total++; if ({bus_rr.rsp1_valid, bus_rr.rsp0_valid} !== 2'b00) begin bad++; $display("FAIL rr_idle got=%b want=00", {bus_rr.rsp1_valid, bus_rr.rsp0_valid}); end
        bus_rr.rsp0_ready = 1'b0; bus_rr.rsp1_ready = 1'b0;
    endtask

    task automatic test_fixed();
        do_reset();
        bus_fp.req0_valid = 1'b1; bus_fp.req0_ctl = C_SUB; bus_fp.req0_a = 32'd10; bus_fp.req0_b = 32'd4;
        bus_fp.req1_valid = 1'b1; bus_fp.req1_ctl = C_OR;  bus_fp.req1_a = 32'hF0; bus_fp.req1_b = 32'h0F;
        bus_fp.rsp0_ready = 1'b1; bus_fp.rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            total++; if ({bus_fp.req1_ready, bus_fp.req0_ready} !== 2'b01) begin bad++; $display("FAIL fp_grant op=%0d got=%b want=01", i, {bus_fp.req1_ready, bus_fp.req0_ready}); end
            tick(); #1;
            total++; if (bus_fp.req1_ready !== 1'b0) begin bad++; $display("FAIL fp_exec_ready1 op=%0d got=%0b want=0", i, bus_fp.req1_ready); end
            tick(); #1;
            total++; if ({bus_fp.rsp1_valid, bus_fp.rsp0_valid, bus_fp.rsp_result} !== {2'b01, 32'd6}) begin bad++; $display("FAIL fp_rsp op=%0d got=%b/%h want=01/6", i, {bus_fp.rsp1_valid, bus_fp.rsp0_valid}, bus_fp.rsp_result); end
        end
        bus_fp.req0_valid = 1'b0; bus_fp.req1_valid = 1'b0;
        tick();
        bus_fp.rsp0_ready = 1'b0; bus_fp.rsp1_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus_rr.req1_valid = 1'b1; bus_rr.req1_ctl = C_BEQ; bus_rr.req1_a = 32'd7; bus_rr.req1_b = 32'd7;
        bus_rr.rsp1_ready = 1'b0;
        #1;
        total++; if (bus_rr.req1_ready !== 1'b1) begin bad++; $display("FAIL bp_accept1 got=%0b want=1", bus_rr.req1_ready); end
        tick();
        bus_rr.req1_valid = 1'b0;
        bus_rr.req0_valid = 1'b1; bus_rr.req0_ctl = C_ADD; bus_rr.req0_a = 32'd1; bus_rr.req0_b = 32'd2;
        #1;
        total++; if (bus_rr.req0_ready !== 1'b0) begin bad++; $display("FAIL bp_exec_ready0 got=%0b want=0", bus_rr.req0_ready); end
        for (int k = 0; k < 5; k++) begin
            tick(); #1;
            total++; if ({bus_rr.rsp1_valid, bus_rr.rsp0_valid, bus_rr.rsp_branch, bus_rr.rsp_result} !== {3'b101, 32'd0}) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b%b%b/%h want=101/0", k, bus_rr.rsp1_valid, bus_rr.rsp0_valid, bus_rr.rsp_branch, bus_rr.rsp_result); end
            total++; if (bus_rr.req0_ready !== 1'b0) begin bad++; $display("FAIL bp_blocked cyc=%0d got=%0b want=0", k, bus_rr.req0_ready); end
        end
        tick();
        bus_rr.rsp1_ready = 1'b1;
        #1;
        total++; if ({bus_rr.rsp1_valid, bus_rr.req0_ready} !== 2'b11) begin bad++; $display("FAIL bp_release got=%b want=11", {bus_rr.rsp1_valid, bus_rr.req0_ready}); end
        tick();
        bus_rr.rsp1_ready = 1'b0; bus_rr.req0_valid = 1'b0; bus_rr.rsp0_ready = 1'b1;
        #1;
        total++; if ({bus_rr.rsp1_valid, rr_a} !== {1'b0, 32'd1}) begin bad++; $display("FAIL bp_next_exec got=%b/%h want=0/1", bus_rr.rsp1_valid, rr_a); end
        tick(); #1;
        total++; if ({bus_rr.rsp0_valid, bus_rr.rsp_result} !== {1'b1, 32'd3}) begin bad++; $display("FAIL bp_next_rsp got=%b/%h want=1/3", bus_rr.rsp0_valid, bus_rr.rsp_result); end
        tick();
        bus_rr.rsp0_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus_rr.req0_valid = 1'b1; bus_rr.req0_ctl = C_XOR; bus_rr.req0_a = 32'hF0; bus_rr.req0_b = 32'hFF;
        bus_rr.rsp0_ready = 1'b1;
        #1;
        total++; if (bus_rr.req0_ready !== 1'b1) begin bad++; $display("FAIL rm_accept got=%0b want=1", bus_rr.req0_ready); end
        tick();
        bus_rr.req0_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        total++; if ({bus_rr.rsp1_valid, bus_rr.rsp0_valid, rr_ctl, rr_a, rr_b} !== 73'd0) begin bad++; $display("FAIL rm_cleared got=%h want=0", {bus_rr.rsp1_valid, bus_rr.rsp0_valid, rr_ctl, rr_a, rr_b}); end
        total++; if ({bus_rr.rsp_branch, bus_rr.rsp_result} !== 33'd0) begin bad++; $display("FAIL rm_result got=%h want=0", {bus_rr.rsp_branch, bus_rr.rsp_result}); end
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            total++; if (bus_rr.rsp0_valid !== 1'b0) begin bad++; $display("FAIL rm_no_rsp cyc=%0d got=%0b want=0", k, bus_rr.rsp0_valid); end
        end
        bus_rr.req0_valid = 1'b1; bus_rr.req0_ctl = C_ADD; bus_rr.req0_a = 32'd2; bus_rr.req0_b = 32'd2;
        bus_rr.req1_valid = 1'b1; bus_rr.req1_ctl = C_ADD; bus_rr.req1_a = 32'd9; bus_rr.req1_b = 32'd9;
        #1;
        total++; if ({bus_rr.req1_ready, bus_rr.req0_ready} !== 2'b01) begin bad++; $display("FAIL rm_first_tie got=%b want=01", {bus_rr.req1_ready, bus_rr.req0_ready}); end
        tick();
        bus_rr.req0_valid = 1'b0; bus_rr.req1_valid = 1'b0;
        tick(); #1;
        total++; if ({bus_rr.rsp0_valid, bus_rr.rsp_result} !== {1'b1, 32'd4}) begin bad++; $display("FAIL rm_tie_rsp got=%b/%h want=1/4", bus_rr.rsp0_valid, bus_rr.rsp_result); end
        tick();
        bus_rr.rsp0_ready = 1'b0;
    endtask

    task automatic test_branch();
        logic [6:0] ctl [2];
        logic       exp [2];
        ctl[0] = C_BLTU; exp[0] = 1'b0;
        ctl[1] = C_BLT;  exp[1] = 1'b1;
        bus_rr.rsp0_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus_rr.req0_valid = 1'b1; bus_rr.req0_ctl = ctl[i]; bus_rr.req0_a = 32'hFFFFFFFF; bus_rr.req0_b = 32'd1;
            tick();
            bus_rr.req0_valid = 1'b0;
            tick(); #1;
            total++; if ({bus_rr.rsp0_valid, bus_rr.rsp_branch} !== {1'b1, exp[i]}) begin bad++; $display("FAIL branch op=%0d got=%b%b want=1%b", i, bus_rr.rsp0_valid, bus_rr.rsp_branch, exp[i]); end
            tick();
        end
        bus_rr.rsp0_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus_rr.req0_valid = 1'b0; bus_rr.req0_ctl = '0; bus_rr.req0_a = '0; bus_rr.req0_b = '0;
        bus_rr.req1_valid = 1'b0; bus_rr.req1_ctl = '0; bus_rr.req1_a = '0; bus_rr.req1_b = '0;
        bus_rr.rsp0_ready = 1'b0; bus_rr.rsp1_ready = 1'b0;
        bus_fp.req0_valid = 1'b0; bus_fp.req0_ctl = '0; bus_fp.req0_a = '0; bus_fp.req0_b = '0;
        bus_fp.req1_valid = 1'b0; bus_fp.req1_ctl = '0; bus_fp.req1_a = '0; bus_fp.req1_b = '0;
        bus_fp.rsp0_ready = 1'b0; bus_fp.rsp1_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_fixed();
        test_backpressure();
        test_reset_mid();
        test_branch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
